// File: rtl/core_pkg.sv
// Shared core constants and register-mask helpers used by decode and writeback.
package core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

    // One-hot mask for a register, empty when not enabled or when addressing x0.
    function automatic reg_mask_t reg_onehot(input reg_addr_t addr, input logic en);
        reg_mask_t mask;
        mask = '0;
        if (en && (addr != '0)) begin
            mask = reg_mask_t'(1) << addr;
        end
        return mask;
    endfunction

endpackage

// File: rtl/decode_scoreboard_if.sv
// Decode-side and writeback-side signals of the register-hazard scoreboard.
interface decode_scoreboard_if;
    import core_pkg::*;

    logic             dec_valid;
    reg_addr_t        rs1;
    reg_addr_t        rs2;
    reg_addr_t        rd;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
    logic             flush;
    logic             wb_valid;
    reg_addr_t        wb_rd;
    logic             kill_valid;
    reg_addr_t        kill_rd;

    logic             issue_ready;
    logic             issue_fire;
    logic             rf_wr_en;
    reg_mask_t        pending;
    logic [XLEN-1:0]  stall_count;
    logic             hazard_timeout;
    logic             protocol_err;

    // Decode/writeback side.
    modport master (
        output dec_valid, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, flush,
        output wb_valid, wb_rd, kill_valid, kill_rd,
        input  issue_ready, issue_fire, rf_wr_en, pending, stall_count,
        input  hazard_timeout, protocol_err
    );

    // Scoreboard side.
    modport slave (
        input  dec_valid, rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd, flush,
        input  wb_valid, wb_rd, kill_valid, kill_rd,
        output issue_ready, issue_fire, rf_wr_en, pending, stall_count,
        output hazard_timeout, protocol_err
    );

endinterface

// File: rtl/stall_watchdog.sv
// Consecutive-stall counter with a sticky timeout flag.
module stall_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q;

    // Count consecutive stalls, saturating at the limit; any non-stall restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (!stall) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter and sticky flag; the flag sets on the edge the count reaches the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == LIMIT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard and issue controller for the decode stage.
module decode_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_scoreboard_if.slave  bus
);

    reg_mask_t       pending_q, pending_d;
    reg_mask_t       wb_mask, kill_mask, set_mask;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
    logic            perr_q, proto_viol;
    logic            hazard, stall;

    // Hazard check looks only at registered state; same-cycle clears never bypass.
    always_comb begin
        hazard = (bus.uses_rs1  & pending_q[bus.rs1]) |
                 (bus.uses_rs2  & pending_q[bus.rs2]) |
                 (bus.writes_rd & pending_q[bus.rd]);
    end

    assign bus.issue_ready = ~hazard;
    assign bus.issue_fire  = bus.dec_valid & ~hazard & ~bus.flush;
    assign bus.rf_wr_en    = bus.wb_valid & (bus.wb_rd != '0);
    assign stall           = bus.dec_valid & hazard & ~bus.flush;

    // Next bitmap, protocol check and saturating stall count.
    always_comb begin
        wb_mask   = reg_onehot(bus.wb_rd, bus.wb_valid);
        kill_mask = reg_onehot(bus.kill_rd, bus.kill_valid);
        set_mask  = reg_onehot(bus.rd, bus.issue_fire & bus.writes_rd);
        // Bit 0 is forced clear so x0 can never hazard.
        pending_d = ((pending_q & ~(wb_mask | kill_mask)) | set_mask) & ~reg_mask_t'(1);
        // Clearing an idle bit, or wb and kill releasing the same register.
        proto_viol = (|((wb_mask | kill_mask) & ~pending_q)) | (|(wb_mask & kill_mask));
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
            perr_q      <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            if (proto_viol) begin
                perr_q <= 1'b1;
            end
        end
    end

    stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .timeout (bus.hazard_timeout)
    );

    assign bus.pending      = pending_q;
    assign bus.stall_count  = stall_cnt_q;
    assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard-style bench for decode_scoreboard: expected outputs are queued when a
// cycle's stimulus is driven and compared when the DUT outputs are sampled.
module tb_decode_scoreboard;
    import core_pkg::*;

    localparam int unsigned TIMEOUT = 4;

    typedef struct packed {
        logic        ir;
        logic        fire;
        logic        wr;
        logic [31:0] pend;
        logic [31:0] stall;
        logic        to;
        logic        perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_scoreboard_if bus();

    decode_scoreboard #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state.
    logic [31:0] m_pend;
    logic [31:0] m_stall;
    int          m_wd;
    logic        m_to;
    logic        m_perr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, want);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_stall = '0;
        m_wd    = 0;
        m_to    = 1'b0;
        m_perr  = 1'b0;
    endtask

    // One clock cycle: called at a negedge, returns at the following negedge.
    task automatic step(input logic dv = 1'b0, input logic [4:0] r1 = 5'd0,
                        input logic u1 = 1'b0, input logic [4:0] r2 = 5'd0,
                        input logic u2 = 1'b0, input logic [4:0] d = 5'd0,
                        input logic wd = 1'b0, input logic fl = 1'b0,
                        input logic wbv = 1'b0, input logic [4:0] wbr = 5'd0,
                        input logic kv = 1'b0, input logic [4:0] kr = 5'd0);
        exp_t        e;
        exp_t        o;
        logic        haz;
        logic        fire;
        logic        stl;
        logic [31:0] nxt;
        bus.dec_valid  = dv;
        bus.rs1        = r1;
        bus.uses_rs1   = u1;
        bus.rs2        = r2;
        bus.uses_rs2   = u2;
        bus.rd         = d;
        bus.writes_rd  = wd;
        bus.flush      = fl;
        bus.wb_valid   = wbv;
        bus.wb_rd      = wbr;
        bus.kill_valid = kv;
        bus.kill_rd    = kr;
        haz  = (u1 && m_pend[r1]) || (u2 && m_pend[r2]) || (wd && m_pend[d]);
        fire = dv && !haz && !fl;
        stl  = dv && haz && !fl;
        e.ir    = !haz;
        e.fire  = fire;
        e.wr    = wbv && (wbr != 5'd0);
        e.pend  = m_pend;
        e.stall = m_stall;
        e.to    = m_to;
        e.perr  = m_perr;
        exp_q.push_back(e);
        #3;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd0, 32'd1);
        end else begin
            o = exp_q.pop_front();
            check_val("issue_ready",    32'(bus.issue_ready),    32'(o.ir));
            check_val("issue_fire",     32'(bus.issue_fire),     32'(o.fire));
            check_val("rf_wr_en",       32'(bus.rf_wr_en),       32'(o.wr));
            check_val("pending",        bus.pending,             o.pend);
            check_val("stall_count",    bus.stall_count,         o.stall);
            check_val("hazard_timeout", 32'(bus.hazard_timeout), 32'(o.to));
            check_val("protocol_err",   32'(bus.protocol_err),   32'(o.perr));
        end
        @(posedge clk);
        if (wbv && wbr != 5'd0 && !m_pend[wbr]) m_perr = 1'b1;
        if (kv && kr != 5'd0 && !m_pend[kr]) m_perr = 1'b1;
        if (wbv && kv && wbr == kr && wbr != 5'd0) m_perr = 1'b1;
        nxt = m_pend;
        if (wbv && wbr != 5'd0) nxt[wbr] = 1'b0;
        if (kv && kr != 5'd0) nxt[kr] = 1'b0;
        if (fire && wd && d != 5'd0) nxt[d] = 1'b1;
        m_pend = nxt;
        if (stl && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (stl) begin
            if (m_wd < int'(TIMEOUT)) m_wd++;
        end else begin
            m_wd = 0;
        end
        if (m_wd == int'(TIMEOUT)) m_to = 1'b1;
        @(negedge clk);
    endtask

    // Drop reset in the middle of a cycle and check the asynchronous clear.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_pending",  bus.pending,                 32'd0);
        check_val("rst_stall",    bus.stall_count,             32'd0);
        check_val("rst_timeout",  32'(bus.hazard_timeout),     32'd0);
        check_val("rst_perr",     32'(bus.protocol_err),       32'd0);
        check_val("rst_ready",    32'(bus.issue_ready),        32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.dec_valid  = 1'b0;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.rd         = '0;
        bus.uses_rs1   = 1'b0;
        bus.uses_rs2   = 1'b0;
        bus.writes_rd  = 1'b0;
        bus.flush      = 1'b0;
        bus.wb_valid   = 1'b0;
        bus.wb_rd      = '0;
        bus.kill_valid = 1'b0;
        bus.kill_rd    = '0;
        rst_n          = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Set then RAW stall released by writeback.
        step(.dv(1), .d(5), .wd(1));
        check_val("raw_set", bus.pending, 32'h20);
        step(.dv(1), .r1(5), .u1(1));
        check_val("raw_stall1", bus.stall_count, 32'd1);
        step(.dv(1), .r1(5), .u1(1));
        step(.dv(1), .r1(5), .u1(1), .wbv(1), .wbr(5));
        check_val("raw_release", 32'(bus.issue_ready), 32'd1);
        check_val("raw_stall3", bus.stall_count, 32'd3);
        step(.dv(1), .r1(5), .u1(1));

        // Three stalls, one issue, three stalls: watchdog stays quiet.
        step(.dv(1), .d(6), .wd(1));
        step(.dv(1), .r2(6), .u2(1));
        step(.dv(1), .r2(6), .u2(1));
        step(.dv(1), .r2(6), .u2(1), .wbv(1), .wbr(6));
        step(.dv(1), .r2(6), .u2(1));
        check_val("wd_no_timeout", 32'(bus.hazard_timeout), 32'd0);

        // Operand-select masking, x0 destination and flush.
        step(.dv(1), .d(5), .wd(1));
        step(.dv(1), .r1(5), .u1(0));
        step(.wbv(1), .wbr(5));
        step(.dv(1), .d(0), .wd(1));
        check_val("x0_never_set", bus.pending, 32'd0);
        step(.dv(1), .d(10), .wd(1), .fl(1));
        check_val("flush_no_set", bus.pending, 32'd0);

        // WAW stall released by kill.
        step(.dv(1), .d(7), .wd(1));
        step(.dv(1), .d(7), .wd(1));
        step(.dv(1), .d(7), .wd(1), .kv(1), .kr(7));
        check_val("waw_killed", 32'(bus.pending[7]), 32'd0);
        step(.dv(1), .d(7), .wd(1));
        check_val("waw_reissue", 32'(bus.pending[7]), 32'd1);
        step(.kv(1), .kr(7));

        // wb and kill on different registers clear in the same edge.
        step(.dv(1), .d(11), .wd(1));
        step(.dv(1), .d(12), .wd(1));
        step(.wbv(1), .wbr(11), .kv(1), .kr(12));
        check_val("dual_clear", bus.pending, 32'd0);
        check_val("dual_no_perr", 32'(bus.protocol_err), 32'd0);

        // Four consecutive stalls trip the sticky watchdog.
        step(.dv(1), .d(8), .wd(1));
        for (int i = 0; i < 4; i++) step(.dv(1), .r1(8), .u1(1));
        check_val("wd_timeout", 32'(bus.hazard_timeout), 32'd1);
        step(.dv(1), .r1(8), .u1(1), .wbv(1), .wbr(8));
        step();
        check_val("wd_sticky", 32'(bus.hazard_timeout), 32'd1);

        // wb and kill hitting the same pending register.
        do_reset();
        step(.dv(1), .d(3), .wd(1));
        step(.wbv(1), .wbr(3), .kv(1), .kr(3));
        check_val("same_clear_bit", bus.pending, 32'd0);
        check_val("same_clear_perr", 32'(bus.protocol_err), 32'd1);

        // Writeback to an idle register.
        do_reset();
        step(.wbv(1), .wbr(9));
        check_val("idle_clear_perr", 32'(bus.protocol_err), 32'd1);
        step();

        // Fill the scoreboard, trip the watchdog, then reset mid-stall.
        for (int i = 1; i < 32; i++) step(.dv(1), .d(5'(i)), .wd(1));
        check_val("fill_pending", bus.pending, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) step(.dv(1), .r1(1), .u1(1));
        check_val("fill_timeout", 32'(bus.hazard_timeout), 32'd1);
        do_reset();
        step(.dv(1), .r1(1), .u1(1), .d(1), .wd(1));
        check_val("post_reset_issue", bus.pending, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
